// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the FIFO write port among NREQ producers
module fifo_wr_arbiter #(
    parameter int NREQ         = 4,
    parameter int OWB          = 2,
    parameter int DW           = 8,
    parameter int MAX_BURST    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   wdata_in,
    input  logic [NREQ-1:0]      last,
    input  logic                 flush_in,
    input  logic                 full,
    output logic [NREQ-1:0]      gnt,
    output logic                 insert,
    output logic [DW-1:0]        wdata,
    output logic                 flush,
    output logic [OWB-1:0]       owner,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [OWB-1:0] PTR_RST    = OWB'(NREQ - 1);
    localparam logic [3:0]     FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [8:0]     BURST_LIM  = 9'(MAX_BURST);

    state_t         state_q, state_d;
    logic [OWB-1:0] owner_q, owner_d;
    logic [OWB-1:0] ptr_q, ptr_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [3:0]     fcnt_q, fcnt_d;
    logic           flush_q, busy_q;

    logic [OWB-1:0] pick;
    logic [OWB-1:0] scan_idx;
    logic           pick_vld;
    logic           accept;
    logic [8:0]     bcnt_inc;

    // First requester strictly after the last owner, wrapping at NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = OWB'((int'(ptr_q) + k) % NREQ);
            if (!pick_vld && req[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Zero-latency acceptance: a word moves in the same cycle gnt is high.
    assign accept   = (state_q == S_BURST) && !flush_in && req[owner_q] && !full;
    assign bcnt_inc = {1'b0, bcnt_q} + 9'd1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = accept && (owner_q == OWB'(i));
        end
    end

    assign insert = accept;
    assign wdata  = accept ? wdata_in[owner_q*DW +: DW] : '0;
    assign flush  = flush_q;
    assign owner  = owner_q;
    assign busy   = busy_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        fcnt_d  = fcnt_q;
        if (flush_in) begin
            state_d = S_FLUSH;
            bcnt_d  = '0;
            if (state_q != S_FLUSH) begin
                fcnt_d = FLUSH_LOAD;
            end else begin
                ptr_d = PTR_RST;
                if (fcnt_q != 4'd0) begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld && !full) begin
                        owner_d = pick;
                        bcnt_d  = '0;
                        state_d = S_BURST;
                    end
                end
                S_BURST: begin
                    if (!req[owner_q]) begin
                        ptr_d   = owner_q;
                        state_d = S_IDLE;
                    end else if (accept) begin
                        bcnt_d = bcnt_inc[7:0];
                        if (last[owner_q] || (bcnt_inc == BURST_LIM)) begin
                            ptr_d   = owner_q;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    ptr_d  = PTR_RST;
                    bcnt_d = '0;
                    if (fcnt_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= PTR_RST;
            bcnt_q  <= '0;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
            flush_q <= (state_d == S_FLUSH);
            busy_q  <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4, OWB = 2, DW = 8, MAX_BURST = 16, FLUSH_CYCLES = 2;

    logic                clk_in = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  wdata_in = '0;
    logic [NREQ-1:0]     last = '0;
    logic                flush_in = 1'b0;
    logic                full = 1'b0;
    logic [NREQ-1:0]     gnt;
    logic                insert;
    logic [DW-1:0]       wdata;
    logic                flush;
    logic [OWB-1:0]      owner;
    logic                busy;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .OWB(OWB), .DW(DW), .MAX_BURST(MAX_BURST), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk_in(clk_in), .rst(rst), .req(req), .wdata_in(wdata_in), .last(last),
        .flush_in(flush_in), .full(full), .gnt(gnt), .insert(insert), .wdata(wdata),
        .flush(flush), .owner(owner), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // Model: who holds the grant, how many words it has moved, last winner, flush age.
    int m_holder = -1;
    int m_last   = NREQ - 1;
    int m_taken  = 0;
    int m_fl_n   = 0;
    int m_owner  = 0;
    int cnt [NREQ];

    int             glog [$];
    logic [DW-1:0]  dlog [$];
    int             flog_count = 0;

    always @(negedge clk_in) begin
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   ed;
        int              gi;
        int              h;
        if (!rst) begin
            m_holder = -1; m_last = NREQ - 1; m_taken = 0; m_fl_n = 0; m_owner = 0;
            for (int i = 0; i < NREQ; i++) cnt[i] = 0;
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_insert", 32'(insert), 0);
            chk("rst_flush", 32'(flush), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_owner", 32'(owner), 0);
        end else begin
            eg = '0;
            ed = '0;
            if (m_holder >= 0 && !flush_in && req[m_holder] && !full) begin
                eg[m_holder] = 1'b1;
                ed = wdata_in[m_holder*DW +: DW];
            end
            chk("gnt", 32'(gnt), 32'(eg));
            chk("insert", 32'(insert), 32'(|eg));
            chk("wdata", 32'(wdata), 32'(ed));
            chk("flush", 32'(flush), 32'(m_fl_n > 0));
            chk("busy", 32'(busy), 32'((m_fl_n > 0) || (m_holder >= 0)));
            chk("owner", 32'(owner), 32'(m_owner));

            gi = -1;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
            glog.push_back(gi);
            if (insert) dlog.push_back(wdata);
            if (flush) flog_count++;
            for (int i = 0; i < NREQ; i++) if (eg[i]) cnt[i]++;

            if (flush_in) begin
                m_holder = -1;
                if (m_fl_n > 0) m_last = NREQ - 1;
                m_fl_n++;
            end else if (m_fl_n > 0) begin
                m_last = NREQ - 1;
                if (m_fl_n >= FLUSH_CYCLES) m_fl_n = 0;
                else m_fl_n++;
            end else if (m_holder < 0) begin
                if (req != 0 && !full) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        h = (m_last + k) % NREQ;
                        if (m_holder < 0 && req[h]) m_holder = h;
                    end
                    m_owner = m_holder;
                    m_taken = 0;
                end
            end else begin
                h = m_holder;
                if (!req[h]) begin
                    m_last = h; m_holder = -1;
                end else if (!full) begin
                    m_taken++;
                    if (last[h] || m_taken == MAX_BURST) begin
                        m_last = h; m_holder = -1;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        glog.delete();
        dlog.delete();
        flog_count = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_in); #2;
        rst = 1'b0; req = '0; last = '0; full = 1'b0; flush_in = 1'b0;
        @(posedge clk_in); #2;
        rst = 1'b1;
        @(negedge clk_in); #1;
        clear_logs();
    endtask

    // Directed data: slice i carries A0 + 16*i + words already accepted from i.
    task automatic step(input logic [NREQ-1:0] r, input int len, input bit f, input bit fl);
        @(posedge clk_in); #2;
        req = r; full = f; flush_in = fl;
        for (int i = 0; i < NREQ; i++) begin
            wdata_in[i*DW +: DW] = 8'hA0 + 8'(16 * i) + 8'(cnt[i]);
            last[i] = (len > 0) && (((cnt[i] + 1) % len) == 0);
        end
    endtask

    task automatic chk_glog(input string name, input string pat);
        chk({name, "_len"}, 32'(glog.size() >= pat.len()), 1);
        for (int i = 0; i < pat.len() && i < glog.size(); i++)
            chk(name, glog[i], (pat[i] == 8'h2D) ? 32'hFFFF_FFFF : 32'(pat[i] - 8'h30));
    endtask

    task automatic chk_dlog(input string name, input int idx, input logic [DW-1:0] v);
        if (idx < dlog.size()) chk(name, 32'(dlog[idx]), 32'(v));
        else chk(name, 32'hDEAD_0000, 32'(v));
    endtask

    int guard;
    int inserts;

    initial begin
        repeat (2) @(posedge clk_in);

        // Single requester, three-word burst.
        do_reset();
        guard = 0;
        while (cnt[0] < 3 && guard < 10) begin
            step(4'b0001, 3, 1'b0, 1'b0);
            guard++;
        end
        step(4'b0000, 0, 1'b0, 1'b0);
        step(4'b0000, 0, 1'b0, 1'b0);
        chk_glog("s1_seq", "-000--");
        chk_dlog("s1_d0", 0, 8'hA0);
        chk_dlog("s1_d1", 1, 8'hA1);
        chk_dlog("s1_d2", 2, 8'hA2);
        chk("s1_owner", 32'(owner), 0);
        chk("s1_busy", 32'(busy), 0);

        // Round robin, one-word bursts.
        do_reset();
        repeat (10) step(4'b1111, 1, 1'b0, 1'b0);
        @(negedge clk_in); #1;
        chk_glog("s2_seq", "-0-1-2-3-0");
        inserts = 0;
        for (int i = 0; i < 10; i++) if (glog[i] >= 0) inserts++;
        chk("s2_duty", 32'(inserts), 5);

        // Burst cap with a competing requester.
        do_reset();
        repeat (20) step(4'b1100, 0, 1'b0, 1'b0);
        @(negedge clk_in); #1;
        chk_glog("s3_seq", "-2222222222222222-33");

        // Backpressure mid-burst.
        do_reset();
        for (int k = 0; k < 10; k++) step(4'b0001, 4, (k >= 2 && k <= 4), 1'b0);
        @(negedge clk_in); #1;
        chk_glog("s4_seq", "-0---000-0");
        chk_dlog("s4_d1", 1, 8'hA1);
        chk_dlog("s4_d3", 3, 8'hA3);

        // Flush pulse on the second word.
        do_reset();
        for (int k = 0; k < 8; k++) step(4'b0001, 0, 1'b0, (k == 2));
        @(negedge clk_in); #1;
        chk_glog("s5_seq", "-0----00");
        chk("s5_flush_len", 32'(flog_count), 2);
        chk_dlog("s5_d1", 1, 8'hA1);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        repeat (3) step(4'b0110, 0, 1'b0, 1'b0);
        @(posedge clk_in); #2;
        rst = 1'b0;
        #1;
        chk("s6_gnt", 32'(gnt), 0);
        chk("s6_insert", 32'(insert), 0);
        chk("s6_flush", 32'(flush), 0);
        chk("s6_busy", 32'(busy), 0);
        @(posedge clk_in); #2;
        rst = 1'b1; req = 4'b1111;
        clear_logs();
        repeat (3) step(4'b1111, 1, 1'b0, 1'b0);
        @(negedge clk_in); #1;
        chk_glog("s6_seq", "-0-");

        // Randomized traffic with sticky requests.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk_in); #2;
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1;
                chk("rnd_rst_gnt", 32'(gnt), 0);
                chk("rnd_rst_busy", 32'(busy), 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
                last[i] = ($urandom_range(0, 9) == 0);
            end
            wdata_in = {$urandom, $urandom};
            full     = ($urandom_range(0, 4) == 0);
            flush_in = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk_in); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
